// File: rtl/instr_mem_ctrl.sv
// Synchronous-read instruction memory with program-load port, post-reset clear
// sequence and a one-cycle fetch handshake. Define IMEM_PARITY_EN for per-word parity.
module instr_mem_ctrl #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     fetch_stall,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [DATA_W-1:0]        fetch_instr,
  output logic                     fetch_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     load_ready,
`ifdef IMEM_PARITY_EN
  output logic                     parity_err,
  input  logic                     inj_par,
`endif
  output logic                     busy
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        clr_cnt_r;
  logic                    fetch_valid_r;
  logic [DATA_W-1:0]       fetch_instr_r;
  logic                    fetch_err_r;
  logic [MEM_W-1:0]        mem_r [DEPTH];

  logic                    wr_en_s;
  logic [IDX_W-1:0]        wr_idx_s;
  logic [MEM_W-1:0]        wr_word_s;
  logic [IDX_W-1:0]        fetch_idx_s;
  logic                    addr_err_s;
  logic [MEM_W-1:0]        rd_word_s;
  logic                    par_bad_s;
  logic                    accept_s;

`ifdef IMEM_PARITY_EN
  logic                    parity_err_r;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  assign fetch_idx_s = fetch_addr[IDX_W+1:2];
  // Out-of-range means any address bit above the word index is set, so nothing wraps.
  assign addr_err_s  = (|fetch_addr[1:0]) | (|fetch_addr[ADDR_W-1:IDX_W+2]);
  assign rd_word_s   = mem_r[fetch_idx_s];
  assign accept_s    = (state_r == ST_RUN) & fetch_req & ~fetch_stall;

`ifdef IMEM_PARITY_EN
  assign par_bad_s   = ^rd_word_s;
`else
  assign par_bad_s   = 1'b0;
`endif

  assign fetch_ready = (state_r == ST_RUN) & ~fetch_stall;
  assign load_ready  = (state_r == ST_RUN);
  assign busy        = (state_r == ST_CLEAR);
  assign fetch_valid = fetch_valid_r;
  assign fetch_instr = fetch_instr_r;
  assign fetch_err   = fetch_err_r;
`ifdef IMEM_PARITY_EN
  assign parity_err  = parity_err_r;
`endif

  // Single write port: clear sequence owns it in CLEAR, program load in RUN.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = {IDX_W{1'b0}};
    wr_word_s = {MEM_W{1'b0}};
    if (state_r == ST_CLEAR) begin
      wr_en_s  = 1'b1;
      wr_idx_s = clr_cnt_r;
`ifdef IMEM_PARITY_EN
      wr_word_s = {even_parity(NOP_WORD), NOP_WORD};
`else
      wr_word_s = NOP_WORD;
`endif
    end else if (load_en) begin
      wr_en_s  = 1'b1;
      wr_idx_s = load_idx;
`ifdef IMEM_PARITY_EN
      wr_word_s = {even_parity(load_data) ^ inj_par, load_data};
`else
      wr_word_s = load_data;
`endif
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array; not reset, the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_word_s;
    end
  end

  // Control FSM and registered fetch outputs; the read sees pre-write data (read-first).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_CLEAR;
      clr_cnt_r     <= {IDX_W{1'b0}};
      fetch_valid_r <= 1'b0;
      fetch_instr_r <= NOP_WORD;
      fetch_err_r   <= 1'b0;
`ifdef IMEM_PARITY_EN
      parity_err_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_CLEAR: begin
          fetch_valid_r <= 1'b0;
          clr_cnt_r     <= clr_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
          if (clr_cnt_r == IDX_W'(DEPTH - 1)) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fetch_stall) begin
            fetch_valid_r <= fetch_valid_r;
          end else if (accept_s) begin
            fetch_valid_r <= 1'b1;
            if (addr_err_s) begin
              fetch_instr_r <= NOP_WORD;
              fetch_err_r   <= 1'b1;
`ifdef IMEM_PARITY_EN
              parity_err_r  <= 1'b0;
`endif
            end else begin
              fetch_instr_r <= rd_word_s[DATA_W-1:0];
              fetch_err_r   <= par_bad_s;
`ifdef IMEM_PARITY_EN
              parity_err_r  <= par_bad_s;
`endif
            end
          end else begin
            fetch_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_CLEAR;
          clr_cnt_r     <= {IDX_W{1'b0}};
          fetch_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed self-checking bench for instr_mem_ctrl (default depth 256).
// Parity checks are compiled in when IMEM_PARITY_EN is defined.
module tb_instr_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_err;
  logic        load_en;
  logic [7:0]  load_idx;
  logic [31:0] load_data;
  logic        load_ready;
  logic        busy;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
  logic        inj_par;
`endif

  int total = 0;
  int bad   = 0;
  int ncyc;

  instr_mem_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_err   (fetch_err),
    .load_en     (load_en),
    .load_idx    (load_idx),
    .load_data   (load_data),
    .load_ready  (load_ready),
`ifdef IMEM_PARITY_EN
    .parity_err  (parity_err),
    .inj_par     (inj_par),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] data);
    load_en = 1'b1; load_idx = idx; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    fetch_req = 1'b1; fetch_addr = addr;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = 32'h0; fetch_stall = 1'b0;
    load_en = 1'b0; load_idx = 8'h0; load_data = 32'h0;
`ifdef IMEM_PARITY_EN
    inj_par = 1'b0;
`endif
    #2;
    check("rst_valid", fetch_valid, 32'd0);
    check("rst_instr", fetch_instr, 32'h0000_0000);
    check("rst_err", fetch_err, 32'd0);
    check("rst_fready", fetch_ready, 32'd0);
    check("rst_lready", load_ready, 32'd0);
    check("rst_busy", busy, 32'd1);
`ifdef IMEM_PARITY_EN
    check("rst_perr", parity_err, 32'd0);
`endif
    tick(); tick(); tick();
    reset = 1'b0;

    // Clear sequence length
    count_clear(ncyc);
    check("clear_cycles", ncyc, 32'd256);
    check("run_lready", load_ready, 32'd1);
    check("run_fready", fetch_ready, 32'd1);
    fetch(32'h3FC);
    check("top_valid", fetch_valid, 32'd1);
    check("top_instr", fetch_instr, 32'h0000_0000);
    check("top_err", fetch_err, 32'd0);

    // Load then back-to-back fetches
    load(8'd0, 32'h2012_0055);
    load(8'd1, 32'h2013_0022);
    load(8'd2, 32'h2015_0077);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    check("seq0_valid", fetch_valid, 32'd1);
    check("seq0_instr", fetch_instr, 32'h2012_0055);
    fetch_addr = 32'h4;
    tick();
    check("seq1_valid", fetch_valid, 32'd1);
    check("seq1_instr", fetch_instr, 32'h2013_0022);
    fetch_addr = 32'h8;
    tick();
    check("seq2_valid", fetch_valid, 32'd1);
    check("seq2_instr", fetch_instr, 32'h2015_0077);
    check("seq2_err", fetch_err, 32'd0);
    fetch_req = 1'b0;
    tick();
    check("idle_valid", fetch_valid, 32'd0);
    check("idle_hold", fetch_instr, 32'h2015_0077);

    // Address errors
    fetch(32'h2);
    check("mis_err", fetch_err, 32'd1);
    check("mis_instr", fetch_instr, 32'h0000_0000);
    fetch(32'h4);
    check("ok_err", fetch_err, 32'd0);
    fetch(32'h400);
    check("oor_valid", fetch_valid, 32'd1);
    check("oor_err", fetch_err, 32'd1);
    check("oor_instr", fetch_instr, 32'h0000_0000);

    // Read-first collision
    load(8'd5, 32'h2011_0044);
    fetch_req = 1'b1; fetch_addr = 32'h14;
    load_en = 1'b1; load_idx = 8'd5; load_data = 32'h2014_0068;
    tick();
    fetch_req = 1'b0; load_en = 1'b0;
    check("rf_old", fetch_instr, 32'h2011_0044);
    fetch(32'h14);
    check("rf_new", fetch_instr, 32'h2014_0068);

    // Stall hold, then reset mid-stall
    fetch(32'h8);
    check("st_instr0", fetch_instr, 32'h2015_0077);
    fetch_stall = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
    #1;
    check("st_fready", fetch_ready, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_valid", fetch_valid, 32'd1);
      check("st_instr", fetch_instr, 32'h2015_0077);
      check("st_fready2", fetch_ready, 32'd0);
    end
    reset = 1'b1;
    #1;
    check("mr_valid", fetch_valid, 32'd0);
    check("mr_busy", busy, 32'd1);
    check("mr_instr", fetch_instr, 32'h0000_0000);
    tick();
    reset = 1'b0; fetch_stall = 1'b0; fetch_req = 1'b0;
    count_clear(ncyc);
    check("reclear_cycles", ncyc, 32'd256);
    fetch(32'h0);
    check("reclear_word0", fetch_instr, 32'h0000_0000);

`ifdef IMEM_PARITY_EN
    inj_par = 1'b1;
    load(8'd7, 32'hDEAD_BEEF);
    inj_par = 1'b0;
    load(8'd6, 32'h2012_0055);
    fetch(32'h1C);
    check("par_instr", fetch_instr, 32'hDEAD_BEEF);
    check("par_err", fetch_err, 32'd1);
    check("par_perr", parity_err, 32'd1);
    fetch(32'h18);
    check("clean_err", fetch_err, 32'd0);
    check("clean_perr", parity_err, 32'd0);
    fetch(32'h1A);
    check("addr_perr", parity_err, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised, synchronous-read instruction memory for the single-cycle and upcoming pipelined MIPS cores. It uses byte addressing with word alignment checking. It has a program-load write port for bench/boot loading and a post-reset hardware clear sequence. Fetch uses a registered, one-cycle-latency request/valid handshake with stall hold.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 32, fetch byte-address width
DEPTH, 256, number of instruction words (power of two, >= 4)
NOP_WORD, 32'h0000_0000, value written during clear and returned on fetch error

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
fetch_req  in  1  fetch request, sampled when fetch_ready=1
fetch_addr  in  ADDR_W  byte address of instruction
fetch_stall  in  1  hold current fetch output; no new fetch accepted
fetch_ready  out  1  block can accept a fetch this cycle
fetch_valid  out  1  fetch_instr/fetch_err valid
fetch_instr  out  DATA_W  fetched instruction
fetch_err  out  1  misaligned or out-of-range fetch
load_en  in  1  program-load write strobe
load_idx  in  $clog2(DEPTH)  word index to write
load_data  in  DATA_W  word to write
load_ready  out  1  load accepted this cycle when load_en=1
busy  out  1  clear sequence in progress

Behaviour:
- Reset is asynchronous and active-high. While reset=1, outputs are: fetch_valid=0, fetch_instr=NOP_WORD, fetch_err=0, fetch_ready=0, load_ready=0, busy=1. The state is CLEAR and the clear counter is 0.
- Memory array contents are not reset asynchronously. They are cleared by the CLEAR state.
- FSM states:
  - CLEAR: writes NOP_WORD to word[cnt] each cycle and increments cnt. After writing word DEPTH-1, moves to RUN. Takes exactly DEPTH cycles after reset deasserts.
  - RUN: steady state. Returns to CLEAR only on reset.
- In CLEAR: busy=1, fetch_ready=0, load_ready=0. fetch_req and load_en are ignored, with no side effects.
- In RUN: busy=0, load_ready=1. fetch_ready = ~fetch_stall.
- Fetch acceptance: a fetch is accepted when fetch_req & fetch_ready. The word index is fetch_addr[$clog2(DEPTH)+1:2].
- Fetch latency is 1 cycle. On the next rising edge, fetch_valid=1 and fetch_instr/fetch_err are registered.
- Fetch errors:
  - A misaligned address (fetch_addr[1:0]!=0) sets fetch_err=1 and fetch_instr=NOP_WORD.
  - An out-of-range address (fetch_addr >= 4*DEPTH, i.e. any set bit above bit $clog2(DEPTH)+1) sets fetch_err=1 and fetch_instr=NOP_WORD.
  - Errors never alias or wrap to a lower address.
- No request: if RUN, fetch_req=0 and fetch_stall=0, then fetch_valid=0 on the next edge. fetch_instr holds its last value.
- Stall: while fetch_stall=1, fetch_valid, fetch_instr and fetch_err hold unchanged. fetch_req is not accepted.
- Load: when RUN and load_en=1, word[load_idx]=load_data at the clock edge.
- Same-cycle fetch and load to the same word uses read-first ordering. The fetch returns the old word; the new word is visible to the next fetch.
- Reset mid-clear or mid-fetch: restarts CLEAR from index 0. Any in-flight fetch is discarded (fetch_valid=0).
- Back-to-back fetches every cycle are supported with sustained throughput of 1 fetch per cycle.

Optional Feature:
Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on load and on clear.
  - A fetch recomputes parity. On mismatch, fetch_err=1 and the stored data is still returned.
  - Adds output port parity_err (1 bit), which distinguishes a parity error from an address error. It resets to 0 and follows the same timing and stall rules as fetch_err.
  - Adds a bench-only input inj_par (1 bit): when asserted with load_en, it stores inverted parity.
- Not defined: no parity storage, no parity_err or inj_par ports, and fetch_err reports address errors only.

Test Plan:
- Clear sequence: assert reset for 3 cycles, then release. busy=1 for exactly 256 cycles, then load_ready=1 and fetch_ready=1. A fetch at addr 0x3FC then returns 0x00000000 with fetch_err=0.
- Load and sequential fetch: load idx0=0x20120055, idx1=0x20130022, idx2=0x20150077. Fetch addresses 0, 4, 8 on consecutive cycles; fetch_valid is high for 3 consecutive cycles with those words in order, one cycle after each request.
- Address errors: fetch 0x2 -> fetch_err=1, fetch_instr=0x00000000. Fetch 0x400 -> fetch_err=1, not aliased to word 0, which holds 0x20120055.
- Read-first collision: word 5=0x20110044; in the same cycle, fetch addr 0x14 and load idx5=0x20140068. Fetch returns 0x20110044, and the next fetch of 0x14 returns 0x20140068.
- Stall and reset: fetch 0x8 and assert fetch_stall for 4 cycles. Output holds 0x20150077 with valid=1 and fetch_ready=0. Assert reset mid-stall: fetch_valid drops to 0 immediately, busy=1, and CLEAR restarts with 256 cycles counted again.
- Parity (IMEM_PARITY_EN): load idx7=0xDEADBEEF with inj_par=1, then fetch 0x1C. Returns 0xDEADBEEF with fetch_err=1 and parity_err=1. A clean word gives parity_err=0.
